// File: rtl/risc16b_mem_pkg.sv
// Shared types and constants for the RISC16B memory host.
//   h_cmd_e   : host command encoding
//   state_e   : CPU run/halt state
//   MEM_WORDS_DEFAULT : default number of 16-bit words in the unified memory
//   sat_inc16 : 16-bit increment that sticks at all-ones
package risc16b_mem_pkg;

   localparam int MEM_WORDS_DEFAULT = 4096;

   typedef enum logic [1:0] {
      CMD_WRITE = 2'b00,
      CMD_READ  = 2'b01,
      CMD_RUN   = 2'b10,
      CMD_HALT  = 2'b11
   } h_cmd_e;

   typedef enum logic {
      ST_HALT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/risc16b_mem_array.sv
// Unified 16-bit word memory: two asynchronous read ports, one synchronous
// write port with per-byte enables. Contents are not reset.
//   clk_i            : write clock
//   ra_idx_i/ra_data_o : read port A (word index / word)
//   rb_idx_i/rb_data_o : read port B (word index / word)
//   we_i             : byte enables, bit0 -> bits 15:8, bit1 -> bits 7:0
//   w_idx_i, w_data_i: write word index and data
module risc16b_mem_array
   import risc16b_mem_pkg::*;
#(
   parameter int WORDS = MEM_WORDS_DEFAULT,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk_i,
   input  logic [AW-1:0] ra_idx_i,
   output logic [15:0]   ra_data_o,
   input  logic [AW-1:0] rb_idx_i,
   output logic [15:0]   rb_data_o,
   input  logic [1:0]    we_i,
   input  logic [AW-1:0] w_idx_i,
   input  logic [15:0]   w_data_i
);

   logic [15:0] mem_q [WORDS];

   assign ra_data_o = mem_q[ra_idx_i];
   assign rb_data_o = mem_q[rb_idx_i];

   always_ff @(posedge clk_i) begin
      if (we_i[0]) mem_q[w_idx_i][15:8] <= w_data_i[15:8];
      if (we_i[1]) mem_q[w_idx_i][7:0]  <= w_data_i[7:0];
   end

endmodule

// File: rtl/risc16b_mem_host.sv
// Host-side controller for a RISC16B CPU with a unified memory.
// The host loads/inspects memory while the CPU is held in reset (HALT),
// releases it (RUN), and stops it again (HALT) reading back a cycle count.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   HALT  | cpu_rst=1, host WRITE/READ served, CPU writes ignored
//   RUN   | cpu_rst=0, CPU writes commit, counter +1 per cycle,
//         | only HALT accepted, other commands answered with r_err=1
//
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   i_addr/i_oe/i_din       : CPU instruction fetch port (comb read)
//   d_addr/d_oe/d_din       : CPU data read port (comb read)
//   d_dout/d_we             : CPU data write (byte enables)
//   cpu_rst                 : active-high reset to CPU
//   h_valid/h_ready/h_cmd/h_addr/h_wdata : host command channel
//   r_valid/r_ready/r_data/r_err         : host response channel
module risc16b_mem_host
   import risc16b_mem_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] i_addr,
   input  logic        i_oe,
   output logic [15:0] i_din,
   input  logic [15:0] d_addr,
   input  logic        d_oe,
   output logic [15:0] d_din,
   input  logic [15:0] d_dout,
   input  logic [1:0]  d_we,
   output logic        cpu_rst,
   input  logic        h_valid,
   output logic        h_ready,
   input  logic [1:0]  h_cmd,
   input  logic [15:0] h_addr,
   input  logic [15:0] h_wdata,
   output logic        r_valid,
   input  logic        r_ready,
   output logic [15:0] r_data,
   output logic        r_err
);

   localparam int AW = $clog2(MEM_WORDS);

   state_e      state_q, state_d;
   logic        cpu_rst_q, cpu_rst_d;
   logic        r_valid_q, r_valid_d;
   logic [15:0] r_data_q, r_data_d;
   logic        r_err_q, r_err_d;
   logic [15:0] cnt_q, cnt_d;

   h_cmd_e        cmd;
   logic          accept, host_wr, host_rd;
   logic [AW-1:0] i_idx, d_idx, h_idx, rb_idx, w_idx;
   logic [1:0]    mem_we;
   logic [15:0]   w_data, ra_data, rb_data, cnt_inc;
   logic          unused_addr_bits;

   // Word index drops the byte bit; bits above the array size wrap.
   assign i_idx = i_addr[AW:1];
   assign d_idx = d_addr[AW:1];
   assign h_idx = h_addr[AW:1];
   assign unused_addr_bits = ^{i_addr, d_addr, h_addr};

   assign cmd     = h_cmd_e'(h_cmd);
   assign h_ready = !r_valid_q || r_ready;
   assign accept  = h_valid && h_ready;

   // Host and CPU writes are exclusive by state, so a plain mux suffices.
   assign host_wr = accept && (state_q == ST_HALT) && (cmd == CMD_WRITE);
   assign mem_we  = host_wr ? 2'b11 : ((state_q == ST_RUN) ? d_we : 2'b00);
   assign w_idx   = host_wr ? h_idx   : d_idx;
   assign w_data  = host_wr ? h_wdata : d_dout;

   // Host reads borrow the data read port; they only happen in HALT, when
   // the CPU is held in reset and not consuming d_din.
   assign host_rd = h_valid && (state_q == ST_HALT) && (cmd == CMD_READ);
   assign rb_idx  = host_rd ? h_idx : d_idx;

   risc16b_mem_array #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_mem (
      .clk_i     (clk),
      .ra_idx_i  (i_idx),
      .ra_data_o (ra_data),
      .rb_idx_i  (rb_idx),
      .rb_data_o (rb_data),
      .we_i      (mem_we),
      .w_idx_i   (w_idx),
      .w_data_i  (w_data)
   );

   assign i_din = i_oe ? ra_data : 16'h0000;
   assign d_din = d_oe ? rb_data : 16'h0000;

   assign cnt_inc = sat_inc16(cnt_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = (state_q == ST_RUN) ? cnt_inc : cnt_q;
      r_valid_d = r_valid_q && !r_ready;
      r_data_d  = r_data_q;
      r_err_d   = r_err_q;
      if (accept) begin
         r_valid_d = 1'b1;
         r_data_d  = 16'h0000;
         r_err_d   = 1'b0;
         if (state_q == ST_HALT) begin
            case (cmd)
               CMD_READ: r_data_d = rb_data;
               CMD_RUN: begin
                  state_d = ST_RUN;
                  cnt_d   = 16'h0000;
               end
               CMD_HALT: r_data_d = cnt_q;
               default: ;
            endcase
         end else begin
            if (cmd == CMD_HALT) begin
               state_d  = ST_HALT;
               // Count includes the cycle on which HALT is accepted.
               r_data_d = cnt_inc;
            end else begin
               r_err_d = 1'b1;
            end
         end
      end
      cpu_rst_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_HALT;
         cpu_rst_q <= 1'b1;
         r_valid_q <= 1'b0;
         r_data_q  <= 16'h0000;
         r_err_q   <= 1'b0;
         cnt_q     <= 16'h0000;
      end else begin
         state_q   <= state_d;
         cpu_rst_q <= cpu_rst_d;
         r_valid_q <= r_valid_d;
         r_data_q  <= r_data_d;
         r_err_q   <= r_err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign cpu_rst = cpu_rst_q;
   assign r_valid = r_valid_q;
   assign r_data  = r_data_q;
   assign r_err   = r_err_q;

endmodule

// File: tb/tb_risc16b_mem_host.sv
// Bench for risc16b_mem_host: directed scenarios plus a randomized run,
// all checked against a word-array / response-queue reference model.
module tb_risc16b_mem_host;

   localparam int AW = 12;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] i_addr, i_din, d_addr, d_din, d_dout, h_addr, h_wdata, r_data;
   logic        i_oe, d_oe, cpu_rst, h_valid, h_ready, r_valid, r_ready, r_err;
   logic [1:0]  d_we, h_cmd;

   always #5 clk = ~clk;

   risc16b_mem_host dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_addr  (i_addr),
      .i_oe    (i_oe),
      .i_din   (i_din),
      .d_addr  (d_addr),
      .d_oe    (d_oe),
      .d_din   (d_din),
      .d_dout  (d_dout),
      .d_we    (d_we),
      .cpu_rst (cpu_rst),
      .h_valid (h_valid),
      .h_ready (h_ready),
      .h_cmd   (h_cmd),
      .h_addr  (h_addr),
      .h_wdata (h_wdata),
      .r_valid (r_valid),
      .r_ready (r_ready),
      .r_data  (r_data),
      .r_err   (r_err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [15:0] mem_m [0:4095];
   bit          run_m = 1'b0;
   int          cyc_m = 0;
   logic [16:0] rq [$];          // {err, data} of responses not yet taken

   // Advance one clock; the model applies the rules to the inputs present
   // just before the edge.
   task automatic tick();
      bit          acc, hs, was_run;
      logic [16:0] resp;
      int          hi, di;
      hs      = (rq.size() > 0) && r_ready;
      acc     = h_valid && ((rq.size() == 0) || r_ready);
      hi      = int'(h_addr[AW:1]);
      di      = int'(d_addr[AW:1]);
      was_run = run_m;
      resp    = '0;
      if (acc) begin
         if (!was_run) begin
            case (h_cmd)
               2'b00: mem_m[hi] = h_wdata;
               2'b01: resp = {1'b0, mem_m[hi]};
               2'b10: run_m = 1'b1;
               default: resp = {1'b0, 16'(cyc_m)};
            endcase
         end else if (h_cmd == 2'b11) begin
            resp  = {1'b0, 16'((cyc_m + 1 > 65535) ? 65535 : cyc_m + 1)};
            run_m = 1'b0;
         end else begin
            resp = {1'b1, 16'h0000};
         end
      end
      if (was_run) begin
         if (d_we[0]) mem_m[di][15:8] = d_dout[15:8];
         if (d_we[1]) mem_m[di][7:0]  = d_dout[7:0];
         if (cyc_m < 65535) cyc_m++;
      end
      if (acc && !was_run && h_cmd == 2'b10) cyc_m = 0;
      if (hs) void'(rq.pop_front());
      if (acc) rq.push_back(resp);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] c, input logic [15:0] a, input logic [15:0] w);
      h_valid = 1'b1;
      h_cmd   = c;
      h_addr  = a;
      h_wdata = w;
      tick();
      h_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_addr = 0; i_oe = 0; d_addr = 0; d_oe = 0; d_dout = 0; d_we = 0;
      h_valid = 0; h_cmd = 0; h_addr = 0; h_wdata = 0; r_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
      checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rst_r_valid: got %b want 0", r_valid); end
      checks++; if (r_data !== 16'h0000) begin errors++; $display("FAIL rst_r_data: got %h want 0000", r_data); end
      checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL rst_r_err: got %b want 0", r_err); end
      rst_n = 1'b1;
      #1;
      checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL rst_h_ready: got %b want 1", h_ready); end
      send(2'b11, 16'h0, 16'h0);
      checks++; if (r_valid !== 1'b1 || r_data !== 16'h0000) begin
         errors++; $display("FAIL rst_counter: got v=%b d=%h want v=1 d=0000", r_valid, r_data); end
   endtask

   task automatic test_write_read();
      send(2'b00, 16'h0000, 16'h1234);
      checks++; if (r_valid !== 1'b1 || r_data !== 16'h0000 || r_err !== 1'b0) begin
         errors++; $display("FAIL wr_resp: got v=%b d=%h e=%b want 1/0000/0", r_valid, r_data, r_err); end
      send(2'b01, 16'h0000, 16'h0);
      checks++; if (r_valid !== 1'b1 || r_data !== 16'h1234 || r_err !== 1'b0) begin
         errors++; $display("FAIL rd_resp: got v=%b d=%h e=%b want 1/1234/0", r_valid, r_data, r_err); end
      // Byte bit and upper bits are ignored: 0x2001 maps to word 0.
      send(2'b01, 16'h2001, 16'h0);
      checks++; if (r_data !== 16'h1234) begin errors++; $display("FAIL rd_wrap: got %h want 1234", r_data); end
   endtask

   task automatic test_cpu_byte_write();
      send(2'b00, 16'h0010, 16'h1234);
      send(2'b00, 16'h0004, 16'h0000);
      send(2'b10, 16'h0, 16'h0);
      checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL run_cpu_rst: got %b want 0", cpu_rst); end
      d_addr = 16'h0011; d_we = 2'b10; d_dout = 16'h00AB; d_oe = 1'b1;
      #1;
      checks++; if (d_din !== 16'h1234) begin errors++; $display("FAIL cpu_rd_old: got %h want 1234", d_din); end
      tick();
      d_we = 2'b00;
      #1;
      checks++; if (d_din !== 16'h12AB) begin errors++; $display("FAIL cpu_rd_new: got %h want 12ab", d_din); end
      // CPU write in the same cycle that HALT is accepted still commits.
      d_addr = 16'h0004; d_we = 2'b11; d_dout = 16'hBEEF;
      send(2'b11, 16'h0, 16'h0);
      d_we = 2'b00; d_oe = 1'b0;
      // Writes while halted are ignored.
      d_we = 2'b11; d_dout = 16'h5555;
      tick();
      d_we = 2'b00;
      send(2'b01, 16'h0010, 16'h0);
      checks++; if (r_data !== 16'h12AB || r_err !== 1'b0) begin
         errors++; $display("FAIL byte_wr: got %h e=%b want 12ab e=0", r_data, r_err); end
      send(2'b01, 16'h0004, 16'h0);
      checks++; if (r_data !== 16'hBEEF) begin errors++; $display("FAIL halt_same_cycle_wr: got %h want beef", r_data); end
   endtask

   task automatic test_reject();
      send(2'b00, 16'h0002, 16'h5A5A);
      send(2'b10, 16'h0, 16'h0);
      send(2'b00, 16'h0002, 16'hFFFF);
      checks++; if (r_err !== 1'b1 || r_data !== 16'h0000) begin
         errors++; $display("FAIL rej_write: got e=%b d=%h want e=1 d=0000", r_err, r_data); end
      send(2'b01, 16'h0002, 16'h0);
      checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL rej_read: got e=%b want 1", r_err); end
      send(2'b10, 16'h0, 16'h0);
      checks++; if (r_err !== 1'b1 || cpu_rst !== 1'b0) begin
         errors++; $display("FAIL rej_run: got e=%b cpu_rst=%b want 1/0", r_err, cpu_rst); end
      send(2'b11, 16'h0, 16'h0);
      send(2'b01, 16'h0002, 16'h0);
      checks++; if (r_data !== 16'h5A5A || r_err !== 1'b0) begin
         errors++; $display("FAIL rej_preserved: got %h e=%b want 5a5a e=0", r_data, r_err); end
   endtask

   task automatic test_counter();
      send(2'b10, 16'h0, 16'h0);
      repeat (9) tick();
      send(2'b11, 16'h0, 16'h0);
      checks++; if (r_data !== 16'd10 || r_err !== 1'b0) begin
         errors++; $display("FAIL cnt_halt: got %0d e=%b want 10 e=0", r_data, r_err); end
      checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL cnt_cpu_rst: got %b want 1", cpu_rst); end
      send(2'b11, 16'h0, 16'h0);
      checks++; if (r_data !== 16'd10) begin errors++; $display("FAIL cnt_hold: got %0d want 10", r_data); end
   endtask

   task automatic test_back_to_back();
      send(2'b01, 16'h0010, 16'h0);
      checks++; if (r_data !== 16'h12AB) begin errors++; $display("FAIL bp_first: got %h want 12ab", r_data); end
      r_ready = 1'b0;
      h_valid = 1'b1; h_cmd = 2'b00; h_addr = 16'h0006; h_wdata = 16'h7777;
      #1;
      checks++; if (h_ready !== 1'b0) begin errors++; $display("FAIL bp_h_ready: got %b want 0", h_ready); end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (r_valid !== 1'b1 || r_data !== 16'h12AB) begin
            errors++; $display("FAIL bp_hold: got v=%b d=%h want 1/12ab", r_valid, r_data); end
      end
      r_ready = 1'b1;
      #1;
      checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", h_ready); end
      tick();
      h_valid = 1'b0;
      checks++; if (r_valid !== 1'b1 || r_data !== 16'h0000) begin
         errors++; $display("FAIL bp_second: got v=%b d=%h want 1/0000", r_valid, r_data); end
      send(2'b01, 16'h0006, 16'h0);
      checks++; if (r_data !== 16'h7777) begin errors++; $display("FAIL bp_written: got %h want 7777", r_data); end
   endtask

   task automatic test_reset_mid_run();
      send(2'b10, 16'h0, 16'h0);
      r_ready = 1'b0;
      send(2'b01, 16'h0010, 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      rq.delete(); run_m = 1'b0; cyc_m = 0;
      checks++; if (cpu_rst !== 1'b1 || r_valid !== 1'b0) begin
         errors++; $display("FAIL rst_mid: got cpu_rst=%b r_valid=%b want 1/0", cpu_rst, r_valid); end
      checks++; if (r_data !== 16'h0000 || r_err !== 1'b0) begin
         errors++; $display("FAIL rst_mid_resp: got d=%h e=%b want 0000/0", r_data, r_err); end
      tick();
      rst_n = 1'b1;
      r_ready = 1'b1;
      #1;
      checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_h_ready: got %b want 1", h_ready); end
      send(2'b01, 16'h0010, 16'h0);
      checks++; if (r_data !== 16'h12AB) begin errors++; $display("FAIL rst_mid_mem: got %h want 12ab", r_data); end
   endtask

   task automatic test_random();
      int r;
      for (int k = 0; k < 8; k++) send(2'b00, 16'(k * 2), 16'($urandom));
      for (int n = 0; n < 400; n++) begin
         h_valid = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         h_cmd   = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
         h_addr  = {3'($urandom), 9'b0, 3'($urandom), 1'($urandom)};
         h_wdata = 16'($urandom);
         r_ready = ($urandom_range(0, 3) != 0);
         i_oe    = 1'($urandom); d_oe = 1'($urandom);
         i_addr  = {3'($urandom), 9'b0, 3'($urandom), 1'($urandom)};
         d_addr  = {3'($urandom), 9'b0, 3'($urandom), 1'($urandom)};
         d_dout  = 16'($urandom);
         d_we    = 2'($urandom);
         #1;
         checks++; if (h_ready !== ((rq.size() == 0) || r_ready)) begin
            errors++; $display("FAIL rnd_h_ready[%0d]: got %b", n, h_ready); end
         checks++; if (i_din !== (i_oe ? mem_m[int'(i_addr[AW:1])] : 16'h0000)) begin
            errors++; $display("FAIL rnd_i_din[%0d]: got %h want %h", n, i_din,
                               i_oe ? mem_m[int'(i_addr[AW:1])] : 16'h0000); end
         if (run_m) begin
            checks++; if (d_din !== (d_oe ? mem_m[int'(d_addr[AW:1])] : 16'h0000)) begin
               errors++; $display("FAIL rnd_d_din[%0d]: got %h want %h", n, d_din,
                                  d_oe ? mem_m[int'(d_addr[AW:1])] : 16'h0000); end
         end
         tick();
         checks++; if (r_valid !== (rq.size() != 0)) begin
            errors++; $display("FAIL rnd_r_valid[%0d]: got %b want %b", n, r_valid, rq.size() != 0); end
         if (rq.size() != 0) begin
            checks++; if (r_data !== rq[0][15:0] || r_err !== rq[0][16]) begin
               errors++; $display("FAIL rnd_resp[%0d]: got d=%h e=%b want d=%h e=%b",
                                  n, r_data, r_err, rq[0][15:0], rq[0][16]); end
         end
         checks++; if (cpu_rst !== !run_m) begin
            errors++; $display("FAIL rnd_cpu_rst[%0d]: got %b want %b", n, cpu_rst, !run_m); end
      end
      h_valid = 1'b0; d_we = 2'b00; r_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_cpu_byte_write();
      test_reject();
      test_counter();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/risc16b_mem_host.md
RISC16B_MEM_HOST -- requirements
Module: risc16b_mem_host

Interface
REQ-001 Parameter MEM_WORDS, 4096, number of 16-bit words in the unified memory; power of two.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_addr  input  16  CPU instruction byte address.
REQ-005 i_oe  input  1  CPU instruction read enable.
REQ-006 i_din  output  16  instruction word to CPU.
REQ-007 d_addr  input  16  CPU data byte address.
REQ-008 d_oe  input  1  CPU data read enable.
REQ-009 d_din  output  16  data word to CPU.
REQ-010 d_dout  input  16  CPU write data.
REQ-011 d_we  input  2  byte write enables; bit0 = bits 15:8 (even byte), bit1 = bits 7:0 (odd byte).
REQ-012 cpu_rst  output  1  active-high reset to CPU.
REQ-013 h_valid, h_ready  input, output  1 each  host command handshake.
REQ-014 h_cmd  input  2  00 WRITE, 01 READ, 10 RUN, 11 HALT.
REQ-015 h_addr, h_wdata  input  16 each  host byte address, write word.
REQ-016 r_valid, r_ready  output, input  1 each  response handshake.
REQ-017 r_data  output  16  response data; r_err  output  1  command rejected.

Function
REQ-018 Word index = addr[log2(MEM_WORDS):1]; addr[0] and upper bits ignored (wrap-around).
REQ-019 i_din, d_din SHALL be combinational reads of the current word when the respective oe=1, else 16'h0000.
REQ-020 States: HALT, RUN; cpu_rst = 1 in HALT, 0 in RUN, registered.
REQ-021 Command accepted on cycle with h_valid && h_ready; h_ready = !r_valid || r_ready.
REQ-022 Every accepted command SHALL produce exactly one response, r_valid high the next cycle, held until r_valid && r_ready.
REQ-023 HALT state: WRITE writes full word at clock edge of acceptance, response r_data=0, r_err=0; READ returns stored word (pre-write contents if same-cycle CPU write impossible), r_err=0; RUN moves to RUN next cycle, clears cycle counter, r_data=0; HALT stays HALT, r_data=counter.
REQ-024 RUN state: WRITE, READ, RUN rejected -- no memory or state change, response r_err=1, r_data=0; HALT moves to HALT next cycle, r_data=counter value including acceptance cycle.
REQ-025 CPU writes (d_we) SHALL commit at clock edge only while state=RUN; ignored in HALT.
REQ-026 HALT accepted in same cycle as CPU d_we: CPU write commits.
REQ-027 Cycle counter 16-bit, +1 per RUN cycle, saturates at 16'hFFFF.
REQ-028 CPU read of a word written same cycle returns old contents; new value visible next cycle.
REQ-029 Host and CPU never write in same cycle (state-exclusive); no arbitration.

Reset
REQ-030 rst_n low: state=HALT, cpu_rst=1, r_valid=0, r_data=0, r_err=0, counter=0, h_ready=1 after release; memory contents not reset.
REQ-031 Reset mid-RUN or with response pending SHALL discard the response and return to HALT immediately.

Structure
REQ-032 Package risc16b_mem_pkg holds h_cmd enum, state enum, MEM_WORDS default.
REQ-033 Sub-module risc16b_mem_array: two async read ports, one write port with 2-bit byte enables.

Verification
REQ-034 After reset WRITE 0x0000=0x1234, READ 0x0000 -> r_data=0x1234, r_err=0, one cycle later.
REQ-035 RUN, CPU d_addr=0x0011 d_we=10 d_dout=0x00AB on word 0x1234, HALT, READ 0x0010 -> 0x12AB.
REQ-036 In RUN, WRITE 0x0002=0xFFFF -> r_err=1; HALT then READ 0x0002 -> original value.
REQ-037 RUN, wait 9 cycles, HALT -> r_data=10 (9 + acceptance), cpu_rst high next cycle.
REQ-038 Hold r_ready=0 two cycles after READ -> h_ready=0, r_valid and r_data stable; second command accepted after r_ready.
REQ-039 Assert rst_n low while RUN with response pending -> cpu_rst=1, r_valid=0 immediately.
